// File: rtl/gpio_debounce.sv
// gpio_debounce: per-channel synchroniser + stable-count debouncer with
// registered edge pulses, sticky event flags and a combined interrupt line.

// One debounced channel: synchroniser, counter, level, pulses, sticky event.
module gpio_debounce_ch #(
  parameter int   SYNC_STAGES  = 2,
  parameter int   DEBOUNCE_CYC = 50000,
  parameter int   CNT_W        = 16,
  parameter logic RST_LEVEL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic [1:0] edge_sel,
  input  logic       clr,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       evt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;
  logic                   evt_set;

  assign synced  = sync[SYNC_STAGES-1];
  // Pulses are registered, so the event lands one cycle after the pulse.
  assign evt_set = (rise & edge_sel[0]) | (fall & edge_sel[1]);

  // Synchroniser chain; only the last stage is looked at by the debouncer.
  always_ff @(posedge clk) begin
    if (rst) sync <= {SYNC_STAGES{RST_LEVEL}};
    else     sync <= {sync[SYNC_STAGES-2:0], din};
  end

  // Count consecutive mismatching cycles; accept the new level on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= RST_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= synced;
        rise  <= synced;
        fall  <= ~synced;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Sticky event: a new matching pulse wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) evt <= 1'b0;
    else     evt <= evt_set | (evt & ~clr);
  end

endmodule

// Top: array of independent channels plus the interrupt reduction.
module gpio_debounce #(
  parameter int   N_CH         = 5,
  parameter int   SYNC_STAGES  = 2,
  parameter int   DEBOUNCE_CYC = 50000,
  parameter int   CNT_W        = 16,
  parameter logic RST_LEVEL    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   i_in,
  input  logic [2*N_CH-1:0] i_edge_sel,
  input  logic [N_CH-1:0]   i_irq_en,
  input  logic [N_CH-1:0]   i_clr,
  output logic [N_CH-1:0]   o_level,
  output logic [N_CH-1:0]   o_rise,
  output logic [N_CH-1:0]   o_fall,
  output logic [N_CH-1:0]   o_event,
  output logic              o_irq
);

  logic [N_CH-1:0][1:0] sel;

  assign sel = i_edge_sel;

  for (genvar n = 0; n < N_CH; n++) begin : g_ch
    gpio_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W),
      .RST_LEVEL   (RST_LEVEL)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .din     (i_in[n]),
      .edge_sel(sel[n]),
      .clr     (i_clr[n]),
      .level   (o_level[n]),
      .rise    (o_rise[n]),
      .fall    (o_fall[n]),
      .evt     (o_event[n])
    );
  end

  // Only combinational output path: registered events gated by enables.
  assign o_irq = |(o_event & i_irq_en);

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce (N_CH=5, SYNC_STAGES=2, DEBOUNCE_CYC=4).
// Each vector is driven for rep cycles; the expected post-edge outputs are
// queued on drive and compared by the monitor just after the rising edge.
module tb_gpio_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] i_in = '0;
  logic [9:0] i_edge_sel = '0;
  logic [4:0] i_irq_en = '0;
  logic [4:0] i_clr = '0;
  logic [4:0] o_level, o_rise, o_fall, o_event;
  logic       o_irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         rep;
    logic       r;
    logic [4:0] din;
    logic [9:0] sel;
    logic [4:0] en;
    logic [4:0] clr;
    logic [4:0] lev;
    logic [4:0] rise;
    logic [4:0] fall;
    logic [4:0] ev;
    logic       irq;
    string      tag;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  gpio_debounce #(
    .N_CH(5), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .CNT_W(16), .RST_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .i_in(i_in), .i_edge_sel(i_edge_sel),
    .i_irq_en(i_irq_en), .i_clr(i_clr), .o_level(o_level), .o_rise(o_rise),
    .o_fall(o_fall), .o_event(o_event), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int rep, logic r, logic [4:0] din, logic [9:0] sel,
                              logic [4:0] en, logic [4:0] clr, logic [4:0] lev,
                              logic [4:0] rise, logic [4:0] fall, logic [4:0] ev,
                              logic irq, string tag);
    vec_t v;
    v.rep = rep; v.r = r; v.din = din; v.sel = sel; v.en = en; v.clr = clr;
    v.lev = lev; v.rise = rise; v.fall = fall; v.ev = ev; v.irq = irq; v.tag = tag;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    for (int k = 0; k < v.rep; k++) begin
      @(negedge clk);
      rst = v.r; i_in = v.din; i_edge_sel = v.sel; i_irq_en = v.en; i_clr = v.clr;
      exp_q.push_back(v);
      @(posedge clk);
    end
  endtask

  // Scoreboard monitor: compare every queued expectation after its edge.
  initial begin
    vec_t e;
    logic [20:0] act, want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act  = {o_level, o_rise, o_fall, o_event, o_irq};
        want = {e.lev, e.rise, e.fall, e.ev, e.irq};
        checks++;
        if (act !== want) begin
          errors++;
          $display("FAIL %s t=%0t: got lvl=%b rise=%b fall=%b evt=%b irq=%b, want lvl=%b rise=%b fall=%b evt=%b irq=%b",
                   e.tag, $time, o_level, o_rise, o_fall, o_event, o_irq,
                   e.lev, e.rise, e.fall, e.ev, e.irq);
        end
      end
    end
  end

  initial begin
    // Reset with inputs high: nothing may leak through.
    tbl.push_back(mk(2, 1, 5'h1F, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "rst_hold"));
    // Clean step on ch0 up and back down.
    tbl.push_back(mk(5, 0, 5'h01, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "a_rise_wait"));
    tbl.push_back(mk(1, 0, 5'h01, 10'h000, 5'h00, 5'h00, 5'h01, 5'h01, 5'h00, 5'h00, 0, "a_rise"));
    tbl.push_back(mk(3, 0, 5'h01, 10'h000, 5'h00, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00, 0, "a_high"));
    tbl.push_back(mk(5, 0, 5'h00, 10'h000, 5'h00, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00, 0, "a_fall_wait"));
    tbl.push_back(mk(1, 0, 5'h00, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h01, 5'h00, 0, "a_fall"));
    tbl.push_back(mk(2, 0, 5'h00, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "a_idle"));
    // ch1: 3-cycle glitch rejected, 4-cycle pulse accepted.
    tbl.push_back(mk(3, 0, 5'h02, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "b_glitch3"));
    tbl.push_back(mk(8, 0, 5'h00, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "b_glitch_idle"));
    tbl.push_back(mk(4, 0, 5'h02, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "b_p4_in"));
    tbl.push_back(mk(1, 0, 5'h00, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "b_p4_wait"));
    tbl.push_back(mk(1, 0, 5'h00, 10'h000, 5'h00, 5'h00, 5'h02, 5'h02, 5'h00, 5'h00, 0, "b_p4_rise"));
    tbl.push_back(mk(3, 0, 5'h00, 10'h000, 5'h00, 5'h00, 5'h02, 5'h00, 5'h00, 5'h00, 0, "b_p4_high"));
    tbl.push_back(mk(1, 0, 5'h00, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h02, 5'h00, 0, "b_p4_fall"));
    tbl.push_back(mk(2, 0, 5'h00, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "b_idle"));
    // ch2 fall-only events with irq enable, masking, mode change and clear.
    tbl.push_back(mk(5, 0, 5'h04, 10'h020, 5'h04, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "c_rise_wait"));
    tbl.push_back(mk(1, 0, 5'h04, 10'h020, 5'h04, 5'h00, 5'h04, 5'h04, 5'h00, 5'h00, 0, "c_rise"));
    tbl.push_back(mk(4, 0, 5'h04, 10'h020, 5'h04, 5'h00, 5'h04, 5'h00, 5'h00, 5'h00, 0, "c_rise_noevt"));
    tbl.push_back(mk(5, 0, 5'h00, 10'h020, 5'h04, 5'h00, 5'h04, 5'h00, 5'h00, 5'h00, 0, "c_fall_wait"));
    tbl.push_back(mk(1, 0, 5'h00, 10'h020, 5'h04, 5'h00, 5'h00, 5'h00, 5'h04, 5'h00, 0, "c_fall"));
    tbl.push_back(mk(3, 0, 5'h00, 10'h020, 5'h04, 5'h00, 5'h00, 5'h00, 5'h00, 5'h04, 1, "c_evt_irq"));
    tbl.push_back(mk(1, 0, 5'h00, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h04, 0, "c_mask_selchg"));
    tbl.push_back(mk(1, 0, 5'h00, 10'h000, 5'h04, 5'h00, 5'h00, 5'h00, 5'h00, 5'h04, 1, "c_unmask"));
    tbl.push_back(mk(1, 0, 5'h00, 10'h000, 5'h04, 5'h04, 5'h00, 5'h00, 5'h00, 5'h00, 0, "c_clr"));
    tbl.push_back(mk(2, 0, 5'h00, 10'h000, 5'h04, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "c_idle"));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // ch3 both-edge events: clear coinciding with a new pulse loses to the set.
    apply(mk(5, 0, 5'h08, 10'h0C0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "d_rise_wait"));
    apply(mk(1, 0, 5'h08, 10'h0C0, 5'h00, 5'h00, 5'h08, 5'h08, 5'h00, 5'h00, 0, "d_rise"));
    apply(mk(4, 0, 5'h08, 10'h0C0, 5'h00, 5'h00, 5'h08, 5'h00, 5'h00, 5'h08, 0, "d_evt"));
    apply(mk(5, 0, 5'h00, 10'h0C0, 5'h00, 5'h00, 5'h08, 5'h00, 5'h00, 5'h08, 0, "d_fall_wait"));
    apply(mk(1, 0, 5'h00, 10'h0C0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h08, 5'h08, 0, "d_fall"));
    apply(mk(1, 0, 5'h00, 10'h0C0, 5'h00, 5'h08, 5'h00, 5'h00, 5'h00, 5'h08, 0, "d_clr_set_wins"));
    apply(mk(1, 0, 5'h00, 10'h0C0, 5'h00, 5'h08, 5'h00, 5'h00, 5'h00, 5'h00, 0, "d_clr_alone"));
    apply(mk(2, 0, 5'h00, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "d_idle"));

    // ch4: reset mid-count discards it; reset with level high gives no fall.
    apply(mk(4, 0, 5'h10, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "r_count"));
    apply(mk(1, 1, 5'h10, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "r_rst_mid"));
    apply(mk(5, 0, 5'h10, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "r_rewait"));
    apply(mk(1, 0, 5'h10, 10'h000, 5'h00, 5'h00, 5'h10, 5'h10, 5'h00, 5'h00, 0, "r_rise"));
    apply(mk(2, 0, 5'h10, 10'h000, 5'h00, 5'h00, 5'h10, 5'h00, 5'h00, 5'h00, 0, "r_high"));
    apply(mk(1, 1, 5'h00, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "r_rst_nofall"));
    apply(mk(2, 0, 5'h00, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "r_idle"));

    // All channels step together.
    apply(mk(5, 0, 5'h1F, 10'h000, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0, "e_wait"));
    apply(mk(1, 0, 5'h1F, 10'h000, 5'h00, 5'h00, 5'h1F, 5'h1F, 5'h00, 5'h00, 0, "e_rise_all"));
    apply(mk(2, 0, 5'h1F, 10'h000, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00, 0, "e_high_all"));

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 SHALL have parameter N_CH, default 5, number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth in flops (>=2).
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 50000, consecutive stable cycles required to accept a change (>=1).
REQ-004 SHALL have parameter CNT_W, default 16, debounce counter width; must hold DEBOUNCE_CYC-1.
REQ-005 SHALL have parameter RST_LEVEL, default 1'b0, reset value of all synchroniser flops and debounced levels.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port i_in  input  N_CH  raw asynchronous pushbutton/switch inputs.
REQ-009 SHALL have port i_edge_sel  input  2*N_CH  per-channel event mode, bits [2n+1:2n]: 00 none, 01 rise, 10 fall, 11 both.
REQ-010 SHALL have port i_irq_en  input  N_CH  per-channel interrupt enable.
REQ-011 SHALL have port i_clr  input  N_CH  per-channel sticky-event clear, one-cycle pulse.
REQ-012 SHALL have port o_level  output  N_CH  debounced level.
REQ-013 SHALL have port o_rise  output  N_CH  one-cycle rising-edge pulse of o_level.
REQ-014 SHALL have port o_fall  output  N_CH  one-cycle falling-edge pulse of o_level.
REQ-015 SHALL have port o_event  output  N_CH  sticky event flags.
REQ-016 SHALL have port o_irq  output  1  OR of (o_event & i_irq_en).

Function
REQ-017 Each channel SHALL pass i_in[n] through SYNC_STAGES flops; only the last stage (sync[n]) feeds the debouncer.
REQ-018 Per channel, counter SHALL clear in any cycle where sync[n] == o_level[n].
REQ-019 Per channel, while sync[n] != o_level[n] and counter < DEBOUNCE_CYC-1, counter SHALL increment by 1.
REQ-020 When sync[n] != o_level[n] and counter == DEBOUNCE_CYC-1, o_level[n] SHALL take sync[n] at the next edge and counter SHALL clear.
REQ-021 Latency: a clean input step SHALL appear on o_level exactly SYNC_STAGES + DEBOUNCE_CYC cycles after the first edge at which i_in is sampled changed.
REQ-022 A glitch where sync[n] differs from o_level[n] for fewer than DEBOUNCE_CYC consecutive cycles SHALL NOT change o_level[n] and SHALL NOT produce any pulse.
REQ-023 o_rise[n]/o_fall[n] SHALL be registered and high for exactly the first cycle o_level[n] shows the new value 1/0; never both high.
REQ-024 o_event[n] SHALL set in the cycle after a pulse matching i_edge_sel[2n+1:2n] (rise with bit 2n, fall with bit 2n+1).
REQ-025 o_event[n] SHALL clear at the edge after i_clr[n]=1; simultaneous set and clear SHALL leave o_event[n]=1 (set wins).
REQ-026 i_edge_sel changes SHALL affect only subsequent pulses; existing o_event bits SHALL be unaffected.
REQ-027 o_irq SHALL be combinational from registered o_event and i_irq_en; no other combinational input-to-output paths.
REQ-028 Channels SHALL be fully independent; simultaneous activity on all channels SHALL be handled in the same cycle.

Reset
REQ-029 While rst=1: sync flops and o_level SHALL be RST_LEVEL on all channels; counters, o_rise, o_fall, o_event SHALL be 0; o_irq SHALL be 0.
REQ-030 Reset mid-debounce SHALL discard partial count; no edge pulse SHALL be generated by reset assertion or release.
REQ-031 If i_in differs from RST_LEVEL after release, the change SHALL be debounced normally (REQ-021) and SHALL produce its edge pulse.

Verification (N_CH=5, SYNC_STAGES=2, DEBOUNCE_CYC=4, RST_LEVEL=0)
REQ-032 Step i_in[0] 0->1 after reset -> o_level[0]=1 exactly 6 cycles later, o_rise[0]=1 for that single cycle, other channels 0.
REQ-033 Pulse i_in[1] high for 3 cycles -> o_level[1], o_rise[1], o_event[1] stay 0; 4-cycle pulse -> o_level[1] high 4 cycles, one o_rise and one o_fall.
REQ-034 i_edge_sel[5:4]=10, i_irq_en[2]=1, toggle i_in[2] 0->1->0 with 10-cycle holds -> o_event[2] sets only after the fall; o_irq=1 next to it; rise sets nothing.
REQ-035 With o_event[3]=1, assert i_clr[3] in the same cycle as a new matching edge pulse -> o_event[3] remains 1; i_clr[3] alone next cycle -> 0.
REQ-036 Assert rst for 1 cycle with channel 4 counter at 2 -> all outputs 0, counter 0; i_in[4] held 1 -> o_level[4]=1 six cycles after release, single o_rise[4].
REQ-037 Drive all 5 inputs 0->1 in the same cycle -> all o_level bits and o_rise bits rise in the same cycle.
